// File: rtl/cigar_encoder.sv
// cigar_encoder: merges the traceback op stream into (op, len, last) CIGAR records held in a
// show-ahead record FIFO. Defining CIGAR_STATS_EN adds per-alignment M/I/D op counters.
module cigar_encoder #(
    parameter int OP_WIDTH   = 2,
    parameter int LEN_WIDTH  = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic [OP_WIDTH-1:0]  op_i,
    input  logic                 op_valid_i,
    input  logic                 done_i,
    output logic [OP_WIDTH-1:0]  cigar_op_o,
    output logic [LEN_WIDTH-1:0] cigar_len_o,
    output logic                 cigar_last_o,
    output logic                 cigar_valid_o,
    input  logic                 cigar_ready_i,
    output logic                 stall_o,
    output logic                 overflow_o
`ifdef CIGAR_STATS_EN
    ,
    output logic [15:0]          stat_m_o,
    output logic [15:0]          stat_i_o,
    output logic [15:0]          stat_d_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX  = {LEN_WIDTH{1'b1}};
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = LEN_WIDTH'(0);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0]  OP_RSVD  = {OP_WIDTH{1'b1}};
    localparam logic [OP_WIDTH-1:0]  OP_ZERO  = OP_WIDTH'(0);
    localparam logic [CW-1:0]        CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]        CNT_STALL = CW'(FIFO_DEPTH - 1);
    localparam logic [AW-1:0]        PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [OP_WIDTH-1:0]  r_cur_op, w_cur_op_nxt;
    logic [LEN_WIDTH-1:0] r_cur_len, w_cur_len_nxt;
    logic                 r_overflow;

    logic [OP_WIDTH-1:0]  r_mem_op   [FIFO_DEPTH];
    logic [LEN_WIDTH-1:0] r_mem_len  [FIFO_DEPTH];
    logic                 r_mem_last [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_op_ok, w_open, w_err;
    logic                 w_push, w_push_last;
    logic [OP_WIDTH-1:0]  w_push_op;
    logic [LEN_WIDTH-1:0] w_push_len;
    logic                 w_pop, w_full, w_wr_en, w_drop;

    assign w_op_ok = op_valid_i && (op_i != OP_RSVD);

    // Next-state, run tracking and record-push selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_op_nxt  = r_cur_op;
        w_cur_len_nxt = r_cur_len;
        w_push        = 1'b0;
        w_push_op     = r_cur_op;
        w_push_len    = r_cur_len;
        w_push_last   = 1'b0;
        w_open        = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_op_ok) begin
                    w_cur_op_nxt  = op_i;
                    w_cur_len_nxt = LEN_ONE;
                    w_open        = 1'b1;
                end else begin
                    w_open        = 1'b0;
                end
                if (done_i) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = w_op_ok ? S_RUN : S_IDLE;
                end
            end
            S_RUN: begin
                if (w_op_ok) begin
                    if ((op_i == r_cur_op) && (r_cur_len != LEN_MAX)) begin
                        w_cur_len_nxt = r_cur_len + LEN_ONE;
                    end else begin
                        w_push        = 1'b1;
                        w_cur_op_nxt  = op_i;
                        w_cur_len_nxt = LEN_ONE;
                    end
                end else begin
                    w_cur_len_nxt = r_cur_len;
                end
                if (done_i) begin
                    w_state_nxt = S_FLUSH;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_FLUSH: begin
                w_push        = 1'b1;
                w_push_last   = 1'b1;
                w_err         = op_valid_i || done_i;
                w_cur_len_nxt = LEN_ZERO;
                w_state_nxt   = S_DRAIN;
                // An empty alignment still gets a terminator record.
                if (r_cur_len == LEN_ZERO) begin
                    w_push_op  = OP_RSVD;
                    w_push_len = LEN_ZERO;
                end else begin
                    w_push_op  = r_cur_op;
                    w_push_len = r_cur_len;
                end
            end
            S_DRAIN: begin
                w_err = op_valid_i || done_i;
                if (r_count == CNT_ZERO) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_cur_len_nxt = LEN_ZERO;
            end
        endcase
    end

    assign w_pop   = (r_count != CNT_ZERO) && cigar_ready_i;
    assign w_full  = (r_count == CNT_FULL);
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    // FSM, open run and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_cur_op   <= OP_ZERO;
            r_cur_len  <= LEN_ZERO;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_op   <= w_cur_op_nxt;
            r_cur_len  <= w_cur_len_nxt;
            r_overflow <= r_overflow || w_err || w_drop;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CNT_ZERO;
        end else begin
            r_wr_ptr <= w_wr_en ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
            r_rd_ptr <= w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Record storage; stale entries are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_op[r_wr_ptr]   <= w_push_op;
            r_mem_len[r_wr_ptr]  <= w_push_len;
            r_mem_last[r_wr_ptr] <= w_push_last;
        end
    end

    assign cigar_valid_o = (r_count != CNT_ZERO);
    assign cigar_op_o    = cigar_valid_o ? r_mem_op[r_rd_ptr]   : OP_ZERO;
    assign cigar_len_o   = cigar_valid_o ? r_mem_len[r_rd_ptr]  : LEN_ZERO;
    assign cigar_last_o  = cigar_valid_o ? r_mem_last[r_rd_ptr] : 1'b0;
    assign stall_o       = (r_count >= CNT_STALL);
    assign overflow_o    = r_overflow;

`ifdef CIGAR_STATS_EN
    localparam logic [OP_WIDTH-1:0] OP_M = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_I = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_D = OP_WIDTH'(2);

    logic [15:0] r_stat_m, r_stat_i, r_stat_d;
    logic        w_accept;

    assign w_accept = w_op_ok && ((r_state == S_IDLE) || (r_state == S_RUN));

    // Saturating per-alignment op counters, restarted when a new alignment opens.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_stat_m <= 16'd0;
            r_stat_i <= 16'd0;
            r_stat_d <= 16'd0;
        end else if (w_open) begin
            r_stat_m <= (op_i == OP_M) ? 16'd1 : 16'd0;
            r_stat_i <= (op_i == OP_I) ? 16'd1 : 16'd0;
            r_stat_d <= (op_i == OP_D) ? 16'd1 : 16'd0;
        end else if (w_accept) begin
            if ((op_i == OP_M) && (r_stat_m != 16'hFFFF)) r_stat_m <= r_stat_m + 16'd1;
            if ((op_i == OP_I) && (r_stat_i != 16'hFFFF)) r_stat_i <= r_stat_i + 16'd1;
            if ((op_i == OP_D) && (r_stat_d != 16'hFFFF)) r_stat_d <= r_stat_d + 16'd1;
        end
    end

    assign stat_m_o = r_stat_m;
    assign stat_i_o = r_stat_i;
    assign stat_d_o = r_stat_d;
`endif

endmodule

// File: tb/tb_cigar_encoder.sv
// Directed bench for cigar_encoder: table-driven alignments plus hand-written
// saturation, overflow, latency and reset sequences.
module tb_cigar_encoder;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [1:0]  op_i = 2'd0;
    logic        op_valid_i = 1'b0;
    logic        done_i = 1'b0;
    logic        cigar_ready_i = 1'b0;

    logic [1:0]  a_op, b_op;
    logic [11:0] a_len;
    logic [3:0]  b_len;
    logic        a_last, a_valid, a_stall, a_ovf;
    logic        b_last, b_valid, b_stall, b_ovf;
`ifdef CIGAR_STATS_EN
    logic [15:0] a_sm, a_si, a_sd, b_sm, b_si, b_sd;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic [11:0] len;
        logic        last;
    } rec_t;

    rec_t q_a[$];
    rec_t q_b[$];

    always #5 clk = ~clk;

    cigar_encoder u_dut (
        .clk(clk), .reset_i(reset_i), .op_i(op_i), .op_valid_i(op_valid_i), .done_i(done_i),
        .cigar_op_o(a_op), .cigar_len_o(a_len), .cigar_last_o(a_last), .cigar_valid_o(a_valid),
        .cigar_ready_i(cigar_ready_i), .stall_o(a_stall), .overflow_o(a_ovf)
`ifdef CIGAR_STATS_EN
        , .stat_m_o(a_sm), .stat_i_o(a_si), .stat_d_o(a_sd)
`endif
    );

    cigar_encoder #(.LEN_WIDTH(4)) u_dut4 (
        .clk(clk), .reset_i(reset_i), .op_i(op_i), .op_valid_i(op_valid_i), .done_i(done_i),
        .cigar_op_o(b_op), .cigar_len_o(b_len), .cigar_last_o(b_last), .cigar_valid_o(b_valid),
        .cigar_ready_i(cigar_ready_i), .stall_o(b_stall), .overflow_o(b_ovf)
`ifdef CIGAR_STATS_EN
        , .stat_m_o(b_sm), .stat_i_o(b_si), .stat_d_o(b_sd)
`endif
    );

    // Record every handshake; inputs change at posedge+1, so negedge sees the upcoming pop.
    always @(negedge clk) begin
        if (!reset_i && cigar_ready_i && a_valid) q_a.push_back({a_op, a_len, a_last});
        if (!reset_i && cigar_ready_i && b_valid) q_b.push_back({b_op, {8'd0, b_len}, b_last});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic d);
        op_valid_i = v;
        op_i       = op;
        done_i     = d;
        @(posedge clk);
        #1;
        op_valid_i = 1'b0;
        op_i       = 2'd0;
        done_i     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic chk_rec(input string name, input rec_t act, input rec_t exp);
        chk(name, {17'd0, act}, {17'd0, exp});
    endtask

    typedef struct {
        string            name;
        int               n_ops;
        logic [7:0][1:0]  ops;
        logic             done_on_last;
        int               n_rec;
        logic [3:0][14:0] recs;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"mmmiid", 6, {2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0}, 1'b0, 3,
                    {15'd0, {2'd2, 12'd1, 1'b1}, {2'd1, 12'd2, 1'b0}, {2'd0, 12'd3, 1'b0}}};
        vecs[1] = '{"empty", 0, 16'd0, 1'b0, 1,
                    {45'd0, {2'd3, 12'd0, 1'b1}}};
        vecs[2] = '{"done_with_op", 3, {10'd0, 2'd1, 2'd0, 2'd0}, 1'b1, 2,
                    {30'd0, {2'd1, 12'd1, 1'b1}, {2'd0, 12'd2, 1'b0}}};
        vecs[3] = '{"rsvd_drop", 4, {8'd0, 2'd2, 2'd0, 2'd3, 2'd0}, 1'b0, 2,
                    {30'd0, {2'd2, 12'd1, 1'b1}, {2'd0, 12'd2, 1'b0}}};
        vecs[4] = '{"idle_op_done", 1, {14'd0, 2'd1}, 1'b1, 1,
                    {45'd0, {2'd1, 12'd1, 1'b1}}};
        vecs[5] = '{"single_d", 1, {14'd0, 2'd2}, 1'b0, 1,
                    {45'd0, {2'd2, 12'd1, 1'b1}}};

        do_reset();
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_op", {30'd0, a_op}, 32'd0);
        chk("rst_len", {20'd0, a_len}, 32'd0);
        chk("rst_last", {31'd0, a_last}, 32'd0);
        chk("rst_stall", {31'd0, a_stall}, 32'd0);
        chk("rst_ovf", {31'd0, a_ovf}, 32'd0);

        // Table vectors run back to back so each relies on DRAIN returning to IDLE.
        cigar_ready_i = 1'b1;
        for (int v = 0; v < 6; v++) begin
            q_a.delete();
            for (int i = 0; i < vecs[v].n_ops; i++)
                drive(1'b1, vecs[v].ops[i], vecs[v].done_on_last && (i == vecs[v].n_ops - 1));
            if (!vecs[v].done_on_last || vecs[v].n_ops == 0) drive(1'b0, 2'd0, 1'b1);
            idle(8);
            chk({vecs[v].name, "_count"}, q_a.size(), vecs[v].n_rec);
            for (int i = 0; i < vecs[v].n_rec && i < q_a.size(); i++)
                chk_rec($sformatf("%s_rec%0d", vecs[v].name, i), q_a[i], vecs[v].recs[i]);
            chk({vecs[v].name, "_empty"}, {31'd0, a_valid}, 32'd0);
            chk({vecs[v].name, "_ovf"}, {31'd0, a_ovf}, 32'd0);
        end

        // Saturation: 20 M ops split at 15 with a 4-bit length field.
        do_reset();
        cigar_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b1, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1);
        idle(8);
        chk("sat4_count", q_b.size(), 2);
        if (q_b.size() == 2) begin
            chk_rec("sat4_rec0", q_b[0], {2'd0, 12'd15, 1'b0});
            chk_rec("sat4_rec1", q_b[1], {2'd0, 12'd5, 1'b1});
        end
        chk("sat12_count", q_a.size(), 1);
        if (q_a.size() == 1) chk_rec("sat12_rec0", q_a[0], {2'd0, 12'd20, 1'b1});

        // Latency: run close visible after the edge, done record two edges later.
        do_reset();
        cigar_ready_i = 1'b0;
        drive(1'b1, 2'd0, 1'b0);
        chk("lat_open_empty", {31'd0, a_valid}, 32'd0);
        drive(1'b1, 2'd2, 1'b0);
        chk_rec("lat_close", {a_op, a_len, a_last}, {2'd0, 12'd1, 1'b0});
        chk("lat_close_valid", {31'd0, a_valid}, 32'd1);
        drive(1'b0, 2'd0, 1'b1);
        chk("lat_done_t1_stall", {31'd0, a_stall}, 32'd0);
        idle(1);
        chk("lat_hold_head", {20'd0, a_len}, 32'd1);
        cigar_ready_i = 1'b1;
        idle(1);
        chk_rec("lat_final", {a_op, a_len, a_last}, {2'd2, 12'd1, 1'b1});
        idle(4);
        chk("lat_ovf", {31'd0, a_ovf}, 32'd0);

        // Overflow: ready low, 10 alternating ops then done into an 8-deep FIFO.
        do_reset();
        cigar_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i % 2 == 0) ? 2'd0 : 2'd1, 1'b0);
            if (i == 6) chk("ovf_stall_6rec", {31'd0, a_stall}, 32'd0);
            if (i == 7) chk("ovf_stall_7rec", {31'd0, a_stall}, 32'd1);
            if (i == 8) chk("ovf_clear_full", {31'd0, a_ovf}, 32'd0);
            if (i == 9) chk("ovf_set_push9", {31'd0, a_ovf}, 32'd1);
        end
        drive(1'b0, 2'd0, 1'b1);
        idle(3);
        chk("ovf_sticky", {31'd0, a_ovf}, 32'd1);
        chk_rec("ovf_head_hold", {a_op, a_len, a_last}, {2'd0, 12'd1, 1'b0});
        q_a.delete();
        cigar_ready_i = 1'b1;
        idle(14);
        chk("ovf_drain_count", q_a.size(), 8);
        for (int i = 0; i < 8 && i < q_a.size(); i++)
            chk_rec($sformatf("ovf_rec%0d", i), q_a[i], {(i % 2 == 0) ? 2'd0 : 2'd1, 12'd1, 1'b0});
        chk("ovf_after_drain", {31'd0, a_ovf}, 32'd1);

        // Ops arriving during FLUSH are dropped and flagged.
        do_reset();
        cigar_ready_i = 1'b1;
        drive(1'b1, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1);
        drive(1'b1, 2'd1, 1'b0);
        idle(6);
        chk("flush_op_ovf", {31'd0, a_ovf}, 32'd1);
        chk("flush_op_count", q_a.size(), 1);
        if (q_a.size() == 1) chk_rec("flush_op_rec", q_a[0], {2'd0, 12'd1, 1'b1});

        // Reset in RUN with three records queued.
        do_reset();
        cigar_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, (i % 2 == 0) ? 2'd0 : 2'd1, 1'b0);
        chk("mid_queued", {31'd0, a_valid}, 32'd1);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("mid_valid", {31'd0, a_valid}, 32'd0);
        chk_rec("mid_outs", {a_op, a_len, a_last}, 15'd0);
        chk("mid_stall", {31'd0, a_stall}, 32'd0);
        q_a.delete();
        cigar_ready_i = 1'b1;
        drive(1'b1, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b1);
        idle(6);
        chk("mid_new_count", q_a.size(), 1);
        if (q_a.size() == 1) chk_rec("mid_new_rec", q_a[0], {2'd0, 12'd1, 1'b1});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
